// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : Program-counter successor with an internal hardware return
//               stack. Holds the fetch address and selects its next value
//               from increment, absolute/conditional jump, PC-relative
//               branch, call/return and interrupt vectoring, or holds on stall.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - synchronous active-high reset
//   stall      - hold all state this cycle
//   irq        - interrupt request (pushes pc_out, vectors to IRQ_VECTOR)
//   ret        - pop return stack into pc_out
//   call       - push pc_out+1, jump to pc_write
//   jmp, abs   - jump to pc_write
//   rel        - pc_out + sign-extended offset
//   pc_write   - absolute target address
//   offset     - signed relative offset
//   pc_out     - registered fetch address
//   pc_nxt     - pc_out+1 (combinational)
//   depth      - number of valid return-stack entries
//   stack_err  - sticky overflow/underflow flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int                ADDR_W       = 16,
    parameter int                OFF_W        = 8,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(4)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             irq,
    input  logic                             ret,
    input  logic                             call,
    input  logic                             jmp,
    input  logic                             abs,
    input  logic                             rel,
    input  logic [ADDR_W-1:0]                pc_write,
    input  logic [OFF_W-1:0]                 offset,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [ADDR_W-1:0]                pc_nxt,
    output logic [$clog2(STACK_DEPTH):0]     depth,
    output logic                             stack_err
);

    localparam int               c_PTR_W = $clog2(STACK_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(STACK_DEPTH);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W:0]   r_depth;
    logic               r_err;
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  w_off_ext;
    logic [ADDR_W-1:0]  w_pc_d;
    logic [c_PTR_W:0]   w_depth_d;
    logic               w_err_d;
    logic               w_push;
    logic [ADDR_W-1:0]  w_push_val;
    logic               w_wr_en;
    logic               w_full;
    logic               w_empty;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_top_idx;

    assign w_pc_nxt  = r_pc + 1'b1;
    assign w_full    = (r_depth == c_FULL);
    assign w_empty   = (r_depth == '0);
    // Low bits of depth address the next free slot; when full they wrap to 0,
    // but a push on full is dropped so that slot is never written then.
    assign w_wr_idx  = r_depth[c_PTR_W-1:0];
    assign w_top_idx = r_depth[c_PTR_W-1:0] - 1'b1;

    generate
        if (OFF_W < ADDR_W) begin : g_sext
            assign w_off_ext = {{(ADDR_W - OFF_W){offset[OFF_W-1]}}, offset};
        end else begin : g_nosext
            assign w_off_ext = offset;
        end
    endgenerate

    // Next-state selection in strict priority order; only the winner acts.
    always_comb begin
        w_pc_d     = r_pc;
        w_depth_d  = r_depth;
        w_err_d    = r_err;
        w_push     = 1'b0;
        w_push_val = w_pc_nxt;
        if (!stall) begin
            if (irq) begin
                // Push the interrupted address itself so it re-executes.
                w_push     = 1'b1;
                w_push_val = r_pc;
                w_pc_d     = IRQ_VECTOR;
            end else if (ret) begin
                if (w_empty) begin
                    w_err_d = 1'b1;
                    w_pc_d  = w_pc_nxt;
                end else begin
                    w_pc_d    = r_stack[w_top_idx];
                    w_depth_d = r_depth - 1'b1;
                end
            end else if (call) begin
                w_push = 1'b1;
                w_pc_d = pc_write;
            end else if (jmp || abs) begin
                w_pc_d = pc_write;
            end else if (rel) begin
                w_pc_d = r_pc + w_off_ext;
            end else begin
                w_pc_d = w_pc_nxt;
            end

            // Overflowing push is dropped but the jump itself still happens.
            if (w_push) begin
                if (w_full) begin
                    w_err_d = 1'b1;
                end else begin
                    w_depth_d = r_depth + 1'b1;
                end
            end
        end
    end

    assign w_wr_en = w_push && !w_full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_d;
            r_depth <= w_depth_d;
            r_err   <= w_err_d;
        end
    end

    // Stack contents need no reset; validity is tracked by r_depth.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack[w_wr_idx] <= w_push_val;
        end
    end

    assign pc_out    = r_pc;
    assign pc_nxt    = w_pc_nxt;
    assign depth     = r_depth;
    assign stack_err = r_err;

endmodule
`default_nettype wire

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter successor: holds the fetch address and computes the next address internally.
- Control modes: increment, absolute jump, conditional jump, PC-relative branch, call/return through an internal hardware return stack, interrupt vectoring and stall.
- Sits between the decode/branch-resolution logic and instruction memory.
- pc_out drives the instruction fetch address.

Parameters:
ADDR_W, 16, address width in bits
OFF_W, 8, width of the signed relative-branch offset (OFF_W <= ADDR_W)
STACK_DEPTH, 8, number of return-stack entries (power of 2, >= 2)
RESET_VECTOR, 0, pc_out value after reset (ADDR_W bits)
IRQ_VECTOR, 4, interrupt entry address (ADDR_W bits)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset, sampled on rising clk edge
stall  in  1  hold all state this cycle
irq  in  1  interrupt request, sampled each cycle
ret  in  1  return: pop stack into pc_out
call  in  1  call: push pc_out+1, jump to pc_write
jmp  in  1  conditional branch taken (flags already resolved upstream); target pc_write
abs  in  1  unconditional absolute jump; target pc_write
rel  in  1  relative branch; target pc_out + sign-extended offset
pc_write  in  ADDR_W  absolute target for call/jmp/abs
offset  in  OFF_W  signed two's-complement relative offset
pc_out  out  ADDR_W  current fetch address (registered)
pc_nxt  out  ADDR_W  pc_out+1, combinational
depth  out  clog2(STACK_DEPTH)+1  current number of valid stack entries (registered)
stack_err  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset: on a rising edge with rst=1, pc_out=RESET_VECTOR, depth=0 and stack_err=0. Stack contents are don't-care. rst overrides every other input, including mid-call or mid-interrupt.
- Priority per cycle, highest first: rst > stall > irq > ret > call > (jmp|abs) > rel > increment. Only the winning action takes effect; lower-priority requests in the same cycle are ignored, not queued.
- stall=1: pc_out, depth, stack contents and stack_err hold. irq is not taken; the requester must hold it.
- irq:
  - Pushes pc_out, so the interrupted instruction re-executes on return.
  - pc_out <= IRQ_VECTOR.
- ret:
  - If depth>0: pc_out <= top entry, depth decrements.
  - If depth==0 (underflow): stack_err <= 1 and pc_out <= pc_nxt; the request acts as a no-op.
- call:
  - Pushes pc_nxt (return address) and sets pc_out <= pc_write.
- Push on full (depth==STACK_DEPTH), by call or irq:
  - The push is dropped; existing entries are not overwritten.
  - depth is unchanged and stack_err <= 1.
  - The jump to pc_write or IRQ_VECTOR still happens.
- jmp or abs: pc_out <= pc_write. The two are equivalent; both are kept for decoder compatibility.
- rel: pc_out <= pc_out + sext(offset), modulo 2^ADDR_W.
- Default: pc_out <= pc_nxt.
- Arithmetic: all address arithmetic wraps modulo 2^ADDR_W. With all-ones, the next address is 0, and a call there pushes 0.
- Latency:
  - One cycle from control inputs to pc_out.
  - pc_nxt is valid in the same cycle as pc_out.
  - A popped value appears on pc_out the cycle after ret.
  - Push-then-pop on consecutive cycles returns the pushed value.
- Stack: LIFO register array with a depth counter; depth is never negative and never exceeds STACK_DEPTH.
- stack_err: once set, it is cleared only by rst.

Test Plan:
1. Reset/increment: rst=1 for 1 cycle, then 3 idle cycles -> pc_out 0,1,2,3; depth=0; stack_err=0.
2. Call/return: at pc_out=0x0010, call with pc_write=0x0200, then 2 idle cycles, then ret -> pc_out 0x0200,0x0201,0x0202,0x0011; depth 1 then 0.
3. Relative and wrap:
   - pc_out=0x0005, rel, offset=0xFB (-5) -> 0x0000.
   - pc_out=0xFFFF idle -> 0x0000.
   - pc_out=0x0000, rel, offset=0x7F -> 0x007F.
4. Priority: irq+call+jmp in one cycle at pc_out=0x0040 -> pc_out=0x0004, stack top=0x0040. The following cycle has stall=1 with ret=1 -> pc_out holds 0x0004 and depth holds 1.
5. Overflow/underflow (STACK_DEPTH=4):
   - 5 nested calls -> depth=4 and stack_err=1 after the 5th; pc_out equals the 5th target.
   - 5 rets -> first 4 return the pushed addresses in LIFO order; the 5th increments pc_out, and stack_err stays 1.
6. Reset mid-operation: depth=3, then rst with call=1 asserted -> pc_out=RESET_VECTOR, depth=0, stack_err=0. A subsequent ret underflows and sets stack_err=1.
